bcd_stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/bcd_digit.sv | 36 +++
 rtl/bcd_stopwatch_ctrl.sv | 83 ++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit counters.
package stopwatch_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAP,
    STOP
  } sw_state_t;
endpackage

// File: rtl/bcd_digit.sv
// Single synchronous mod-10 counter; clr has priority over en, at_max flags the digit sitting at 9.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             at_max
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q >= BCD_MAX) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap stopwatch: run FSM, lap register and wrap detection around a cascade of BCD digits.
module bcd_stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    tick,
  input  logic                    btn_ss,
  input  logic                    btn_lap,
  output logic [BCD_W*DIGITS-1:0] disp,
  output logic                    running,
  output logic                    lap_hold,
  output logic                    wrap
);

  sw_state_t               state_q;
  logic [BCD_W*DIGITS-1:0] lap_q;
  logic                    wrap_q;

  logic [BCD_W*DIGITS-1:0] count;
  logic [DIGITS-1:0]       at_max;
  logic [DIGITS:0]         carry;
  logic                    counting;
  logic                    clr_count;

  assign counting  = tick && ((state_q == RUN) || (state_q == LAP));
  // btn_ss wins over a coincident btn_lap, so the clear only fires on a lone lap press.
  assign clr_count = (state_q == STOP) && btn_lap && !btn_ss;
  assign carry[0]  = counting;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign carry[gi+1] = carry[gi] & at_max[gi];

      bcd_digit u_digit (
        .clk    (clk),
        .clear_n(clear_n),
        .en     (carry[gi]),
        .clr    (clr_count),
        .q      (count[BCD_W*gi +: BCD_W]),
        .at_max (at_max[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= carry[DIGITS];
      case (state_q)
        IDLE: if (btn_ss) state_q <= RUN;
        RUN: begin
          if (btn_ss) begin
            state_q <= STOP;
          end else if (btn_lap) begin
            state_q <= LAP;
            lap_q   <= count;
          end
        end
        LAP: begin
          if (btn_ss) state_q <= STOP;
          else if (btn_lap) state_q <= RUN;
        end
        STOP: begin
          if (btn_ss) state_q <= RUN;
          else if (btn_lap) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign running  = (state_q == RUN) || (state_q == LAP);
  assign lap_hold = (state_q == LAP);
  assign disp     = lap_hold ? lap_q : count;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for the stopwatch; a 4-digit and a 2-digit instance share stimulus against a decimal model.
module tb_bcd_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        tick = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_lap = 1'b0;
  logic [15:0] disp0;
  logic [7:0]  disp1;
  logic        running0, running1, lap_hold0, lap_hold1, wrap0, wrap1;

  int tests = 0;
  int fails = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.DIGITS(4)) dut0 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .disp(disp0), .running(running0), .lap_hold(lap_hold0), .wrap(wrap0)
  );

  bcd_stopwatch_ctrl #(.DIGITS(2)) dut1 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .disp(disp1), .running(running1), .lap_hold(lap_hold1), .wrap(wrap1)
  );

  // Model: mode 0 idle, 1 running live, 2 running with frozen lap, 3 stopped.
  int m_mode[2];
  int m_cnt[2];
  int m_lap[2];
  bit m_wrap[2];
  int modulus[2] = '{10000, 100};

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge clear_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!clear_n) begin
        m_mode[i] <= 0;
        m_cnt[i]  <= 0;
        m_lap[i]  <= 0;
        m_wrap[i] <= 1'b0;
      end else begin
        bit adv;
        int nc;
        adv = tick && (m_mode[i] == 1 || m_mode[i] == 2);
        nc  = adv ? (m_cnt[i] + 1) % modulus[i] : m_cnt[i];
        m_wrap[i] <= adv && (m_cnt[i] == modulus[i] - 1);
        case (m_mode[i])
          0: if (btn_ss) m_mode[i] <= 1;
          1: if (btn_ss) m_mode[i] <= 3;
             else if (btn_lap) begin m_mode[i] <= 2; m_lap[i] <= m_cnt[i]; end
          2: if (btn_ss) m_mode[i] <= 3;
             else if (btn_lap) m_mode[i] <= 1;
          default: if (btn_ss) m_mode[i] <= 1;
                   else if (btn_lap) begin m_mode[i] <= 0; nc = 0; end
        endcase
        m_cnt[i] <= nc;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("disp0", {16'h0, disp0}, to_bcd(m_mode[0] == 2 ? m_lap[0] : m_cnt[0]) & 32'hFFFF);
      chk("disp1", {24'h0, disp1}, to_bcd(m_mode[1] == 2 ? m_lap[1] : m_cnt[1]) & 32'hFF);
      chk("running0", {31'h0, running0}, {31'h0, (m_mode[0] == 1 || m_mode[0] == 2)});
      chk("running1", {31'h0, running1}, {31'h0, (m_mode[1] == 1 || m_mode[1] == 2)});
      chk("lap_hold0", {31'h0, lap_hold0}, {31'h0, (m_mode[0] == 2)});
      chk("lap_hold1", {31'h0, lap_hold1}, {31'h0, (m_mode[1] == 2)});
      chk("wrap0", {31'h0, wrap0}, {31'h0, m_wrap[0]});
      chk("wrap1", {31'h0, wrap1}, {31'h0, m_wrap[1]});
    end
  end

  task automatic cyc(input bit ss, input bit lp, input bit tk);
    btn_ss  = ss;
    btn_lap = lp;
    tick    = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_on = 1'b1;
    clear_n = 1'b0;
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_disp", {16'h0, disp0}, 32'h0);
    chk("reset_flags", {29'h0, running0, lap_hold0, wrap0}, 32'h0);
    clear_n = 1'b1;

    cyc(0, 1, 1);
    chk("idle_ignores_lap", {30'h0, running0, lap_hold0}, 32'h0);
    $display("[TB] reset/idle: disp0=%h", disp0);

    cyc(1, 0, 0);
    ticks(10);
    chk("carry_10", {16'h0, disp0}, 32'h0010);
    ticks(99);
    chk("carry_109", {16'h0, disp0}, 32'h0109);
    chk("carry_109_d2", {24'h0, disp1}, 32'h09);
    $display("[TB] count/carry: disp0=%h disp1=%h", disp0, disp1);

    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("stop_lap_clear", {16'h0, disp0}, 32'h0);
    cyc(1, 0, 0);
    ticks(25);
    cyc(0, 1, 0);
    chk("lap_capture", {15'h0, lap_hold0, disp0}, 32'h1_0025);
    ticks(5);
    chk("lap_frozen", {16'h0, disp0}, 32'h0025);
    cyc(0, 1, 0);
    chk("lap_release", {15'h0, lap_hold0, disp0}, 32'h0_0030);
    $display("[TB] lap: disp0=%h lap_hold0=%b", disp0, lap_hold0);

    ticks(12);
    cyc(1, 0, 0);
    ticks(3);
    chk("stop_hold", {15'h0, running0, disp0}, 32'h0_0042);
    cyc(1, 0, 1);
    ticks(2);
    chk("resume", {16'h0, disp0}, 32'h0044);
    cyc(1, 0, 1);
    chk("tick_with_stop_counted", {15'h0, running0, disp0}, 32'h0_0045);
    cyc(0, 1, 1);
    chk("clear_to_idle", {15'h0, running0, disp0}, 32'h0);
    $display("[TB] stop/resume/clear: disp0=%h", disp0);

    cyc(1, 0, 0);
    ticks(99);
    chk("pre_wrap_d2", {24'h0, disp1}, 32'h99);
    ticks(1);
    chk("wrap_d2", {23'h0, wrap1, disp1}, 32'h100);
    chk("no_wrap_d4", {15'h0, wrap0, disp0}, 32'h0_0100);
    ticks(1);
    chk("wrap_one_cycle", {23'h0, wrap1, disp1}, 32'h001);
    $display("[TB] wrap: disp1=%h wrap1=%b", disp1, wrap1);

    cyc(1, 1, 0);
    chk("ss_beats_lap", {30'h0, running0, lap_hold0}, 32'h0);
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    ticks(3);
    chk("relap_hold", {31'h0, lap_hold0}, 32'h1);
    @(posedge clk);
    #3;
    clear_n = 1'b0;
    #1;
    chk("async_disp", {8'h0, disp1, disp0}, 32'h0);
    chk("async_flags", {26'h0, running0, lap_hold0, wrap0, running1, lap_hold1, wrap1}, 32'h0);
    $display("[TB] async reset mid-lap: disp0=%h", disp0);
    repeat (2) @(posedge clk);
    #1;
    clear_n = 1'b1;
    cyc(0, 0, 0);
    model_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
